// File: rtl/alu_pkg.sv
// Shared op-code encoding, FSM state type and op classification helpers for the sequential ALU.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    // Codes 0-5 match the legacy combinational ALU
    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_AND  = 4'd2;
    localparam alu_op_t ALU_OR   = 4'd3;
    localparam alu_op_t ALU_MUL  = 4'd4;
    localparam alu_op_t ALU_SLL  = 4'd5;
    localparam alu_op_t ALU_XOR  = 4'd6;
    localparam alu_op_t ALU_SRL  = 4'd7;
    localparam alu_op_t ALU_SRA  = 4'd8;
    localparam alu_op_t ALU_SLT  = 4'd9;
    localparam alu_op_t ALU_SLTU = 4'd10;
    localparam alu_op_t ALU_DIVU = 4'd11;
    localparam alu_op_t ALU_REMU = 4'd12;
    localparam alu_op_t ALU_LAST = ALU_REMU;

    typedef enum logic [1:0] {
        IDLE,
        MUL_RUN,
        DIV_RUN,
        DONE
    } state_t;

    function automatic logic is_multicycle(input alu_op_t op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    function automatic logic is_legal(input alu_op_t op);
        return op <= ALU_LAST;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative WIDTH-cycle engine: shift-add multiply (LSB first) and restoring unsigned divide
// (MSB first) sharing one counter, accumulator and pair of shift registers.
module alu_iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             div_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             run_q, run_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // acc: running product (mul) or partial remainder (div)
    logic [WIDTH-1:0] acc_q, acc_d;
    // sa: multiplicand (mul) or dividend shifting out / quotient shifting in (div)
    logic [WIDTH-1:0] sa_q, sa_d;
    // sb: multiplier (mul) or divisor (div)
    logic [WIDTH-1:0] sb_q, sb_d;

    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH:0]   partial;
    logic [WIDTH+1:0] diff;
    logic             q_bit;
    logic [WIDTH-1:0] new_rem;
    logic [WIDTH-1:0] new_quo;

    always_comb begin
        mul_sum = acc_q + (sb_q[0] ? sa_q : '0);
        partial = {acc_q, sa_q[WIDTH-1]};
        diff    = {1'b0, partial} - {2'b00, sb_q};
        // No borrow means the shifted remainder covers the divisor
        q_bit   = ~diff[WIDTH+1];
        new_rem = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        new_quo = {sa_q[WIDTH-2:0], q_bit};
    end

    always_comb begin
        run_d = run_q;
        div_d = div_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        sa_d  = sa_q;
        sb_d  = sb_q;
        if (start) begin
            run_d = 1'b1;
            div_d = div_sel;
            cnt_d = CW'(WIDTH - 1);
            acc_d = '0;
            sa_d  = op_a;
            sb_d  = op_b;
        end else if (run_q) begin
            if (div_q) begin
                acc_d = new_rem;
                sa_d  = new_quo;
            end else begin
                acc_d = mul_sum;
                sa_d  = sa_q << 1;
                sb_d  = sb_q >> 1;
            end
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            sa_q  <= '0;
            sb_q  <= '0;
        end else begin
            run_q <= run_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            sa_q  <= sa_d;
            sb_q  <= sb_d;
        end
    end

    // Results are the values produced by the final step, valid while done is high
    assign done      = run_q && (cnt_q == '0);
    assign product   = mul_sum;
    assign quotient  = new_quo;
    assign remainder = new_rem;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides: single-cycle ops complete at accept,
// MUL/DIVU/REMU run through the iterative engine, results are held until consumed.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_zero,
    output logic             alu_illegal
);

    state_t           state_q, state_d;
    logic             rem_sel_q, rem_sel_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_product;
    logic [WIDTH-1:0] md_quotient;
    logic [WIDTH-1:0] md_remainder;
    logic [WIDTH-1:0] div_result;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] comb_result;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign md_start  = accept && is_multicycle(alu_op);
    assign shamt     = operand2[SHW-1:0];
    assign div_result = rem_sel_q ? md_remainder : md_quotient;

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .div_sel   (alu_op != ALU_MUL),
        .op_a      (operand1),
        .op_b      (operand2),
        .done      (md_done),
        .product   (md_product),
        .quotient  (md_quotient),
        .remainder (md_remainder)
    );

    always_comb begin
        comb_result = '0;
        case (alu_op)
            ALU_ADD:  comb_result = operand1 + operand2;
            ALU_SUB:  comb_result = operand1 - operand2;
            ALU_AND:  comb_result = operand1 & operand2;
            ALU_OR:   comb_result = operand1 | operand2;
            ALU_XOR:  comb_result = operand1 ^ operand2;
            ALU_SLL:  comb_result = operand1 << shamt;
            ALU_SRL:  comb_result = operand1 >> shamt;
            ALU_SRA:  comb_result = $signed(operand1) >>> shamt;
            ALU_SLT:  comb_result = {{(WIDTH-1){1'b0}}, $signed(operand1) < $signed(operand2)};
            ALU_SLTU: comb_result = {{(WIDTH-1){1'b0}}, operand1 < operand2};
            default:  comb_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rem_sel_d = rem_sel_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_sel_d = (alu_op == ALU_REMU);
                    if (!is_legal(alu_op)) begin
                        result_d  = '0;
                        zero_d    = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = DONE;
                    end else if (alu_op == ALU_MUL) begin
                        state_d = MUL_RUN;
                    end else if (is_multicycle(alu_op)) begin
                        state_d = DIV_RUN;
                    end else begin
                        result_d  = comb_result;
                        zero_d    = (comb_result == '0);
                        illegal_d = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            MUL_RUN: begin
                if (md_done) begin
                    result_d  = md_product;
                    zero_d    = (md_product == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DIV_RUN: begin
                if (md_done) begin
                    result_d  = div_result;
                    zero_d    = (div_result == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_sel_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_sel_q <= rem_sel_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = (state_q == DONE);
    assign alu_result  = result_q;
    assign alu_zero    = zero_q;
    assign alu_illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: literal per-op expectations plus a cycle-level reference model
// compared against the DUT on every falling edge.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic [3:0]   alu_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         alu_illegal;

    int checks = 0;
    int errors = 0;

    alu_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .operand1    (operand1),
        .operand2    (operand2),
        .alu_op      (alu_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_illegal (alu_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the op definitions
    function automatic logic [W-1:0] model_f(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a * b;
            4'd5:  r = a << b[4:0];
            4'd6:  r = a ^ b;
            4'd7:  r = a >> b[4:0];
            4'd8:  r = $signed(a) >>> b[4:0];
            4'd9:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd10: r = (a < b) ? 1 : 0;
            4'd11: r = (b == 0) ? '1 : a / b;
            4'd12: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Cycle-level model: busy from accept until the result is consumed
    bit           m_busy = 0;
    int           m_wait = 0;
    logic [W-1:0] m_res  = '0;
    logic         m_zero = 0;
    logic         m_ill  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0;
            m_wait = 0;
            check("m_rst_out_valid", out_valid, 0);
            check("m_rst_in_ready", in_ready, 1);
            check("m_rst_result", alu_result, 0);
            check("m_rst_zero", alu_zero, 0);
            check("m_rst_illegal", alu_illegal, 0);
        end else begin
            check("m_in_ready", in_ready, !m_busy);
            check("m_out_valid", out_valid, m_busy && m_wait == 0);
            if (m_busy && m_wait == 0) begin
                check("m_result", alu_result, m_res);
                check("m_zero", alu_zero, m_zero);
                check("m_illegal", alu_illegal, m_ill);
            end
            if (m_busy) begin
                if (m_wait > 0) m_wait--;
                else if (out_ready) m_busy = 0;
            end else if (in_valid) begin
                m_busy = 1;
                m_wait = (alu_op == 4 || alu_op == 11 || alu_op == 12) ? W : 0;
                m_res  = model_f(alu_op, operand1, operand2);
                m_zero = (m_res == 0);
                m_ill  = (alu_op > 12);
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 of the first cycle out_valid is seen
    task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat,
                         input bit exp_ill, input bit offer_busy);
        int n;
        int lat;
        bit ready_leak;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_ready_wait"}, (n < 100), 1);
        in_valid = 1'b1;
        alu_op   = op;
        operand1 = a;
        operand2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        if (offer_busy) begin
            in_valid = 1'b1;
            alu_op   = 4'd0;
        end
        lat = 1;
        ready_leak = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_leak = 1;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, alu_result, exp);
        check({name, "_zero"}, alu_zero, (exp == 0));
        check({name, "_illegal"}, alu_illegal, exp_ill);
        if (offer_busy) check({name, "_busy_in_ready"}, ready_leak, 0);
    endtask

    initial begin
        logic [W-1:0] held;
        bit           stable;
        bit           stale;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operand1  = '0;
        operand2  = '0;
        alu_op    = '0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", alu_result, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h2, 32'h1, 1, 0, 0);
        @(posedge clk); #1;
        check("add_in_ready_next", in_ready, 1);
        check("add_out_valid_next", out_valid, 0);

        do_op("sub_zero", 4'd1, 32'd5, 32'd5, 32'h0, 1, 0, 0);
        do_op("sra", 4'd8, 32'h8000_0000, 32'h21, 32'hC000_0000, 1, 0, 0);
        do_op("slt", 4'd9, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 0, 0);
        do_op("sltu", 4'd10, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 0);
        do_op("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, 0, 0);
        do_op("or", 4'd3, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1, 0, 0);
        do_op("xor", 4'd6, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1, 0, 0);
        do_op("sll", 4'd5, 32'h0000_0003, 32'h0000_0104, 32'h0000_0030, 1, 0, 0);
        do_op("srl", 4'd7, 32'h8000_0000, 32'h1F, 32'h0000_0001, 1, 0, 0);

        do_op("mul", 4'd4, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 33, 0, 1);
        do_op("mul_wrap", 4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0, 0);
        do_op("divu", 4'd11, 32'd100, 32'd7, 32'd14, 33, 0, 0);
        do_op("remu", 4'd12, 32'd100, 32'd7, 32'd2, 33, 0, 0);
        do_op("divu_by0", 4'd11, 32'd9, 32'd0, 32'hFFFF_FFFF, 33, 0, 0);
        do_op("remu_by0", 4'd12, 32'd9, 32'd0, 32'd9, 33, 0, 0);
        do_op("divu_big", 4'd11, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33, 0, 0);

        // Backpressure: result held while out_ready is low
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_op("mul_bp", 4'd4, 32'd3, 32'd5, 32'd15, 33, 0, 0);
        held   = alu_result;
        stable = 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || alu_result !== held) stable = 0;
        end
        check("bp_stable", stable, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        do_op("illegal14", 4'd14, 32'h1234, 32'h5678, 32'h0, 1, 1, 0);

        // Reset during cycle 10 of a divide
        @(posedge clk); #1;
        in_valid = 1'b1;
        alu_op   = 4'd11;
        operand1 = 32'd100;
        operand2 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_result", alu_result, 0);
        check("midrst_zero", alu_zero, 0);
        check("midrst_illegal", alu_illegal, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stale = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1;
        end
        check("no_stale_valid", stale, 0);

        do_op("post_rst_add", 4'd0, 32'd40, 32'd2, 32'd42, 1, 0, 0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
